// File: rtl/count_arbiter.sv
// count_arbiter: round-robin owner selection for one shared up-counter.
// A granted requester gets a count run 0..Limit (latched at the grant),
// followed by a one-cycle Done pulse to that requester.
// Optional build macro COUNT_ARB_ABORT_EN: an owner dropping its Req during
// RUN ends the run early, with no Done pulse.
module count_arbiter #(
    parameter int N_REQ = 4,
    parameter int WIDTH = 4
) (
    input  logic                   CLK,
    input  logic                   Reset,
    input  logic [N_REQ-1:0]       Req,
    input  logic [N_REQ*WIDTH-1:0] Limit,
    output logic [N_REQ-1:0]       Grant,
    output logic                   Busy,
    output logic [N_REQ-1:0]       Done,
    output logic [WIDTH-1:0]       Number
);

    localparam int IW = $clog2(N_REQ);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t             state, state_n;
    logic [IW-1:0]      ptr, ptr_n;
    logic [IW-1:0]      owner, owner_n;
    logic [WIDTH-1:0]   lim, lim_n;
    logic [WIDTH-1:0]   number_n;
    logic [N_REQ-1:0]   grant_n, done_n;
    logic               busy_n;
    logic [IW-1:0]      win;
    logic               found;
    logic [WIDTH-1:0]   lim_arr [N_REQ];

    // Unpack the per-requester terminal values.
    for (genvar g = 0; g < N_REQ; g++) begin : g_lim
        assign lim_arr[g] = Limit[g*WIDTH +: WIDTH];
    end

    // Round-robin search: first requester after the pointer, wrapping.
    always_comb begin
        logic [IW:0] sum;
        win   = ptr;
        found = 1'b0;
        sum   = '0;
        for (int k = 1; k <= N_REQ; k++) begin
            sum = {1'b0, ptr} + (IW+1)'(k);
            if (sum >= (IW+1)'(N_REQ))
                sum = sum - (IW+1)'(N_REQ);
            if (!found && Req[sum[IW-1:0]]) begin
                found = 1'b1;
                win   = sum[IW-1:0];
            end
        end
    end

    // Next-state and next-output logic; every output is registered below.
    always_comb begin
        state_n  = state;
        ptr_n    = ptr;
        owner_n  = owner;
        lim_n    = lim;
        number_n = Number;
        grant_n  = '0;
        done_n   = '0;
        busy_n   = 1'b0;
        case (state)
            IDLE: begin
                if (found) begin
                    owner_n  = win;
                    lim_n    = lim_arr[win];
                    grant_n  = N_REQ'(1) << win;
                    number_n = '0;
                    busy_n   = 1'b1;
                    state_n  = RUN;
                end
            end
            RUN: begin
                busy_n  = 1'b1;
                grant_n = Grant;
`ifdef COUNT_ARB_ABORT_EN
                if (!Req[owner]) begin
                    // Owner withdrew: drop the run, keep the partial count.
                    state_n = IDLE;
                    busy_n  = 1'b0;
                    grant_n = '0;
                    ptr_n   = owner;
                end else
`endif
                if (Number == lim) begin
                    state_n = DONE;
                    grant_n = '0;
                    done_n  = N_REQ'(1) << owner;
                end else begin
                    number_n = Number + WIDTH'(1);
                end
            end
            DONE: begin
                // Busy falls and Done clears on the way back to IDLE.
                ptr_n   = owner;
                state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge CLK) begin
        if (Reset) begin
            state  <= IDLE;
            ptr    <= IW'(N_REQ-1);
            owner  <= '0;
            lim    <= '0;
            Grant  <= '0;
            Busy   <= 1'b0;
            Done   <= '0;
            Number <= '0;
        end else begin
            state  <= state_n;
            ptr    <= ptr_n;
            owner  <= owner_n;
            lim    <= lim_n;
            Grant  <= grant_n;
            Busy   <= busy_n;
            Done   <= done_n;
            Number <= number_n;
        end
    end

endmodule

// File: tb/tb_count_arbiter.sv
// tb_count_arbiter: directed test-plan scenarios plus random traffic, with a
// timeline-based reference model checked against the DUT every cycle.
module tb_count_arbiter;

    localparam int N = 4;
    localparam int W = 4;

    logic             CLK = 1'b0;
    logic             Reset;
    logic [N-1:0]     Req;
    logic [N*W-1:0]   Limit;
    logic [N-1:0]     Grant;
    logic             Busy;
    logic [N-1:0]     Done;
    logic [W-1:0]     Number;

    int checks = 0;
    int errors = 0;

    // Model: a run is described by its grant edge, owner and limit; all
    // outputs follow from the offset of the current edge from the grant edge.
    int m_edge = 0;
    bit m_act  = 1'b0;
    int m_t0, m_L, m_own;
    int m_ptr  = N-1;
    int m_last = 0;
    int eg, eb, ed, en;

    count_arbiter #(.N_REQ(N), .WIDTH(W)) dut (
        .CLK(CLK), .Reset(Reset), .Req(Req), .Limit(Limit),
        .Grant(Grant), .Busy(Busy), .Done(Done), .Number(Number)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (edge %0d)", nm, act, exp, m_edge);
        end
    endtask

    task automatic model_edge();
        int k;
        m_edge++;
        if (Reset) begin
            m_act  = 1'b0;
            m_ptr  = N-1;
            m_last = 0;
        end else if (m_act) begin
            k = m_edge - m_t0;
`ifdef COUNT_ARB_ABORT_EN
            if (k >= 1 && k <= m_L+1 && !Req[m_own]) begin
                m_act  = 1'b0;
                m_ptr  = m_own;
                m_last = k-1;
            end else
`endif
            if (k == m_L+2) begin
                m_act  = 1'b0;
                m_ptr  = m_own;
                m_last = m_L;
            end
        end else if (Req != '0) begin
            for (int j = 1; j <= N; j++) begin
                if (Req[(m_ptr+j) % N]) begin
                    m_own = (m_ptr+j) % N;
                    break;
                end
            end
            m_L   = int'(Limit[m_own*W +: W]);
            m_t0  = m_edge;
            m_act = 1'b1;
        end
        eg = 0; eb = 0; ed = 0; en = m_last;
        if (m_act) begin
            k  = m_edge - m_t0;
            eb = 1;
            if (k <= m_L) begin
                eg = 1 << m_own;
                en = k;
            end else begin
                ed = 1 << m_own;
                en = m_L;
            end
        end
    endtask

    // One clock: advance the model at the edge, compare just after it.
    task automatic step();
        @(posedge CLK);
        model_edge();
        #1;
        chk("grant",  int'(Grant),  eg);
        chk("busy",   int'(Busy),   eb);
        chk("done",   int'(Done),   ed);
        chk("number", int'(Number), en);
    endtask

    task automatic do_reset();
        Reset = 1'b1; Req = '0;
        step(); step();
        Reset = 1'b0;
    endtask

    initial begin
        int gseq [$];
        int dcnt;
        logic [N-1:0] prevg;
        Reset = 1'b1; Req = '0; Limit = '0;

        // Reset for 2 cycles, then 10 idle cycles.
        do_reset();
        for (int i = 0; i < 10; i++) step();
        chk("idle_grant_lit", int'(Grant), 0);
        chk("idle_number_lit", int'(Number), 0);

        // Single requester 0, limit 3.
        Limit[3:0] = 4'd3; Req = 4'b0001;
        step(); Req = '0;
        chk("r0_first_lit", int'({Grant, Number}), 8'h10);
        for (int i = 1; i < 4; i++) step();
        chk("r0_last_lit", int'({Grant, Number}), 8'h13);
        step();
        chk("r0_done_lit", int'({Grant, Done, Busy}), 9'b0000_0001_1);
        step();
        chk("r0_busy_off_lit", int'(Busy), 0);

        // All requesting, all limits 1: rotation from requester 0.
        do_reset();
        Limit = {4'd1, 4'd1, 4'd1, 4'd1}; Req = 4'b1111;
        prevg = '0; dcnt = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (Grant != '0 && Grant != prevg) gseq.push_back(int'(Grant));
            if (Done != '0) dcnt++;
            prevg = Grant;
        end
        Req = '0;
        chk("rr_count_lit", gseq.size(), 5);
        if (gseq.size() == 5) begin
            chk("rr_g0_lit", gseq[0], 1);
            chk("rr_g1_lit", gseq[1], 2);
            chk("rr_g2_lit", gseq[2], 4);
            chk("rr_g3_lit", gseq[3], 8);
            chk("rr_g4_lit", gseq[4], 1);
        end
        chk("rr_done_cnt_lit", dcnt, 5);
        step(); step();

        // Limit 0 on requester 2.
        do_reset();
        Limit = '0; Req = 4'b0100;
        step(); Req = '0;
        chk("lim0_run_lit", int'({Grant, Number}), 8'h40);
        step();
        chk("lim0_done_lit", int'({Grant, Done}), 8'h04);
        step();

        // Full-scale limit on requester 1: no wrap.
        do_reset();
        Limit[7:4] = 4'hF; Req = 4'b0010;
        step(); Req = '0;
        for (int i = 1; i < 16; i++) step();
        chk("full_top_lit", int'({Grant, Number}), 8'h2F);
        step();
        chk("full_done_lit", int'({Done, Number}), 8'h2F);
        step(); step();
        chk("full_hold_lit", int'({Grant, Busy, Number}), 9'b0000_0_1111);

        // Reset mid-run on requester 3 at Number=5.
        do_reset();
        Limit[15:12] = 4'hA; Req = 4'b1000;
        for (int i = 0; i < 6; i++) step();
        chk("mid_num5_lit", int'(Number), 5);
        Reset = 1'b1;
        step();
        Reset = 1'b0;
        chk("mid_reset_lit", int'({Grant, Busy, Done, Number}), 13'd0);
        Req = '0;
        step();

        // Random traffic with occasional resets.
        for (int i = 0; i < 3000; i++) begin
            Reset = ($urandom_range(0, 99) == 0);
            Req   = ($urandom_range(0, 3) == 0) ? '0 : N'($urandom_range(0, 15));
            for (int r = 0; r < N; r++)
                Limit[r*W +: W] = ($urandom_range(0, 3) == 0) ? W'($urandom_range(0, 15))
                                                              : W'($urandom_range(0, 3));
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
